uart_rx_bridge: RTL and testbench

// - Receive path companion to the UART transmit bridge: 8N1 serial receiver plus data-memory write-back.
// - Sits beside the CPU on dpram port 2; each received byte goes to RX_DATA_ADDR and raises a status word at RX_STATUS_ADDR.
// - CPU polls RX_STATUS_ADDR, reads RX_DATA_ADDR, then writes any value to RX_STATUS_ADDR to acknowledge.

---
 rtl/uart_rx_bridge.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bridge.sv
// 8N1 serial receiver that writes each received byte and a "byte available"
// flag into the data memory through dpram port 2, alongside the CPU.
module uart_rx_bridge #(
  parameter int          CLK_FREQ       = 50_000_000,
  parameter int          BAUD           = 115200,
  parameter logic [11:0] RX_STATUS_ADDR = 12'h802,
  parameter logic [11:0] RX_DATA_ADDR   = 12'h803
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        rxd,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_we,
  output logic [11:0] dp_addr,
  output logic [15:0] dp_din,
  output logic        dp_we,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_STAT} wr_state_e;

  logic             sync1_q, sync2_q, rxPrev_q;
  rx_state_e        rxState_q, rxState_d;
  logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             frameErr_q, frameErr_d;
  logic             byteValid;

  wr_state_e        wrState_q, wrState_d;
  logic [11:0]      dpAddr_q, dpAddr_d;
  logic [15:0]      dpDin_q, dpDin_d;
  logic             dpWe_q, dpWe_d;
  logic             rxFull_q, rxFull_d;
  logic             overrun_q, overrun_d;
  logic             ack, accept;

  // rxd is asynchronous; idle-high reset keeps a spurious start edge from appearing out of reset
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= rxd;
      sync2_q  <= sync1_q;
      rxPrev_q <= sync2_q;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rxState_q  <= RX_IDLE;
      clkCnt_q   <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      rxState_q  <= rxState_d;
      clkCnt_q   <= clkCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    rxState_d  = rxState_q;
    clkCnt_d   = clkCnt_q + 1'b1;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    frameErr_d = 1'b0;
    byteValid  = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        clkCnt_d = '0;
        if (rxPrev_q && !sync2_q) begin
          rxState_d = RX_START;
          bitCnt_d  = '0;
        end
      end
      RX_START: begin
        // A line that is high again at mid-start-bit was only a glitch
        if (clkCnt_q == HALF_LAST) begin
          clkCnt_d  = '0;
          rxState_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) rxState_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d  = '0;
          rxState_d = RX_IDLE;
          if (sync2_q) byteValid  = 1'b1;
          else         frameErr_d = 1'b1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wrState_q <= W_INIT;
      dpAddr_q  <= RX_STATUS_ADDR;
      dpDin_q   <= 16'h0000;
      dpWe_q    <= 1'b1;
      rxFull_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wrState_q <= wrState_d;
      dpAddr_q  <= dpAddr_d;
      dpDin_q   <= dpDin_d;
      dpWe_q    <= dpWe_d;
      rxFull_q  <= rxFull_d;
      overrun_q <= overrun_d;
    end
  end

  // An ack racing our own status write would be overwritten, so it is ignored then
  assign ack    = cpu_we && (cpu_addr == RX_STATUS_ADDR)
                  && (wrState_q != W_DATA) && (wrState_q != W_STAT);
  assign accept = byteValid && (!rxFull_q || ack);

  always_comb begin
    wrState_d = wrState_q;
    dpAddr_d  = dpAddr_q;
    dpDin_d   = dpDin_q;
    dpWe_d    = 1'b0;
    rxFull_d  = rxFull_q;
    overrun_d = overrun_q;
    if (ack) begin
      rxFull_d  = 1'b0;
      overrun_d = 1'b0;
    end
    if (accept)         rxFull_d  = 1'b1;
    else if (byteValid) overrun_d = 1'b1;
    case (wrState_q)
      W_INIT, W_IDLE: begin
        if (accept) begin
          wrState_d = W_DATA;
          dpAddr_d  = RX_DATA_ADDR;
          dpDin_d   = {8'h00, shift_q};
          dpWe_d    = 1'b1;
        end else begin
          wrState_d = W_IDLE;
          dpAddr_d  = RX_STATUS_ADDR;
        end
      end
      W_DATA: begin
        wrState_d = W_STAT;
        dpAddr_d  = RX_STATUS_ADDR;
        dpDin_d   = 16'h0001;
        dpWe_d    = 1'b1;
      end
      W_STAT: begin
        wrState_d = W_IDLE;
        dpAddr_d  = RX_STATUS_ADDR;
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  assign dp_addr   = dpAddr_q;
  assign dp_din    = dpDin_q;
  assign dp_we     = dpWe_q;
  assign rx_busy   = (rxState_q != RX_IDLE);
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Directed bench for uart_rx_bridge: serial frames in, dpram write-back
// sequence, glitch rejection, framing error, overrun and mid-frame reset.
module tb_uart_rx_bridge;

  localparam int          CPB  = 434;
  localparam logic [11:0] STAT = 12'h802;
  localparam logic [11:0] DADR = 12'h803;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [11:0] cpu_addr = 12'h000;
  logic        cpu_we = 1'b0;
  logic [11:0] dp_addr;
  logic [15:0] dp_din;
  logic        dp_we;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [15:0] din;
  } wr_t;

  wr_t  wrQ[$];
  wr_t  monW;
  int   feHigh = 0;
  int   fePulses = 0;
  logic feLast = 1'b0;

  uart_rx_bridge dut (
    .clock     (clock),
    .rst       (rst),
    .rxd       (rxd),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .dp_addr   (dp_addr),
    .dp_din    (dp_din),
    .dp_we     (dp_we),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every dpram write and frame_err activity, sampled mid-cycle
  always @(negedge clock) begin
    if (!rst && dp_we) begin
      monW.cyc  = cyc;
      monW.addr = dp_addr;
      monW.din  = dp_din;
      wrQ.push_back(monW);
    end
    if (frame_err) feHigh++;
    if (frame_err && !feLast) fePulses++;
    feLast = frame_err;
  end

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, output int startCyc);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    @(posedge clock); #2;
    startCyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(posedge clock);
      #2;
    end
    rxd = 1'b1;
  endtask

  task automatic ackCpu();
    @(posedge clock); #2;
    cpu_we   = 1'b1;
    cpu_addr = STAT;
    @(posedge clock); #2;
    cpu_we   = 1'b0;
    cpu_addr = 12'h000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if (dp_we !== 1'b1 || dp_addr !== STAT || dp_din !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_dp: got we=%b addr=%h din=%h expected we=1 addr=802 din=0000", dp_we, dp_addr, dp_din);
    end
    checks++;
    if (rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got busy=%b fe=%b ovr=%b expected 0 0 0", rx_busy, frame_err, overrun);
    end
    @(posedge clock); #2;
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if (dp_we !== 1'b1 || dp_addr !== STAT || dp_din !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL init_write: got we=%b addr=%h din=%h expected we=1 addr=802 din=0000", dp_we, dp_addr, dp_din);
    end
    @(negedge clock);
    checks++;
    if (dp_we !== 1'b0 || dp_addr !== STAT || rx_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL init_idle: got we=%b addr=%h busy=%b expected we=0 addr=802 busy=0", dp_we, dp_addr, rx_busy);
    end
  endtask

  // Stop sample lands about 4126 cycles after the start-bit fall (sync + 9.5 bits)
  task automatic test_valid_byte(input logic [7:0] b, input logic doAck);
    int s;
    wrQ.delete();
    applyStimulus(b, 1'b1, s);
    repeat (4) @(negedge clock);
    checks++;
    if (wrQ.size() != 2) begin
      failures++;
      $display("[TB] FAIL byte_%h_count: got %0d writes expected 2", b, wrQ.size());
    end else begin
      checks++;
      if (wrQ[0].addr !== DADR || wrQ[0].din !== {8'h00, b}) begin
        failures++;
        $display("[TB] FAIL byte_%h_data: got %h<=%h expected 803<=%h", b, wrQ[0].addr, wrQ[0].din, {8'h00, b});
      end
      checks++;
      if (wrQ[0].cyc - s < 4122 || wrQ[0].cyc - s > 4130) begin
        failures++;
        $display("[TB] FAIL byte_%h_latency: got %0d cycles expected 4122..4130", b, wrQ[0].cyc - s);
      end
      checks++;
      if (wrQ[1].addr !== STAT || wrQ[1].din !== 16'h0001 || wrQ[1].cyc != wrQ[0].cyc + 1) begin
        failures++;
        $display("[TB] FAIL byte_%h_status: got %h<=%h dt=%0d expected 802<=0001 dt=1", b, wrQ[1].addr, wrQ[1].din, wrQ[1].cyc - wrQ[0].cyc);
      end
    end
    checks++;
    if (dp_we !== 1'b0 || dp_addr !== STAT || rx_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL byte_%h_idle: got we=%b addr=%h busy=%b expected 0 802 0", b, dp_we, dp_addr, rx_busy);
    end
    if (doAck) ackCpu();
  endtask

  task automatic test_glitch();
    wrQ.delete();
    fePulses = 0;
    feHigh = 0;
    @(posedge clock); #2;
    rxd = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_busy: got %b expected 1", rx_busy);
    end
    repeat (90) @(posedge clock);
    #2;
    rxd = 1'b1;
    repeat (400) @(negedge clock);
    checks++;
    if (rx_busy !== 1'b0 || wrQ.size() != 0 || fePulses != 0) begin
      failures++;
      $display("[TB] FAIL glitch_reject: got busy=%b writes=%0d fe=%0d expected 0 0 0", rx_busy, wrQ.size(), fePulses);
    end
  endtask

  task automatic test_frame_error();
    int s;
    wrQ.delete();
    fePulses = 0;
    feHigh = 0;
    applyStimulus(8'h3C, 1'b0, s);
    repeat (4) @(negedge clock);
    checks++;
    if (fePulses != 1 || feHigh != 1) begin
      failures++;
      $display("[TB] FAIL frame_err_pulse: got pulses=%0d width=%0d expected 1 1", fePulses, feHigh);
    end
    checks++;
    if (wrQ.size() != 0 || overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL frame_err_nowrite: got writes=%0d ovr=%b expected 0 0", wrQ.size(), overrun);
    end
    test_valid_byte(8'h3C, 1'b1);
  endtask

  task automatic test_overrun();
    int s;
    wrQ.delete();
    applyStimulus(8'h11, 1'b1, s);
    repeat (4) @(negedge clock);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovr_first: got %b expected 0", overrun);
    end
    applyStimulus(8'h22, 1'b1, s);
    repeat (4) @(negedge clock);
    checks++;
    if (wrQ.size() != 2 || overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovr_drop: got writes=%0d ovr=%b expected 2 1", wrQ.size(), overrun);
    end else begin
      checks++;
      if (wrQ[0].addr !== DADR || wrQ[0].din !== 16'h0011) begin
        failures++;
        $display("[TB] FAIL ovr_kept: got %h<=%h expected 803<=0011", wrQ[0].addr, wrQ[0].din);
      end
    end
    ackCpu();
    @(negedge clock);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovr_ack: got %b expected 0", overrun);
    end
    test_valid_byte(8'h33, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h5A;
    @(posedge clock); #2;
    rxd = 1'b0;
    repeat (CPB) @(posedge clock);
    #2;
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clock);
      #2;
    end
    @(negedge clock);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_busy: got %b expected 1", rx_busy);
    end
    @(posedge clock); #2;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if (rx_busy !== 1'b0 || dp_we !== 1'b1 || dp_addr !== STAT || dp_din !== 16'h0000 || overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_values: got busy=%b we=%b addr=%h din=%h ovr=%b expected 0 1 802 0000 0", rx_busy, dp_we, dp_addr, dp_din, overrun);
    end
    wrQ.delete();
    @(posedge clock); #2;
    rst = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (wrQ.size() != 1) begin
      failures++;
      $display("[TB] FAIL midrst_init_count: got %0d writes expected 1", wrQ.size());
    end else begin
      checks++;
      if (wrQ[0].addr !== STAT || wrQ[0].din !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL midrst_init_write: got %h<=%h expected 802<=0000", wrQ[0].addr, wrQ[0].din);
      end
    end
    test_valid_byte(8'h5A, 1'b1);
  endtask

  initial begin
    test_reset();
    test_valid_byte(8'hA5, 1'b1);
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
